// File: rtl/squash_arbiter.sv
// Squash arbiter: keeps the oldest pending branch-mispredict/violation redirect and fires it at commit.
// Optional perf counters are enabled by defining SQUASH_ARB_PERF_EN.

`ifndef MEMDEP_FOLDPC_WIDTH
`define MEMDEP_FOLDPC_WIDTH 10
`endif

module squash_arbiter #(
    parameter int unsigned NUM_BRU  = 2,
    parameter int unsigned ROB_SIZE = 64,
    parameter int unsigned XLEN     = 64,
    parameter int unsigned FOLD_W   = `MEMDEP_FOLDPC_WIDTH,
    localparam int unsigned RIW     = $clog2(ROB_SIZE) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_BRU-1:0]      i_bwb_vld,
    input  logic [NUM_BRU*RIW-1:0]  i_bwb_rob_idx,
    input  logic [NUM_BRU-1:0]      i_bwb_taken,
    input  logic [NUM_BRU*XLEN-1:0] i_bwb_npc,
    input  logic                    i_vio_vld,
    input  logic [RIW-1:0]          i_vio_rob_idx,
    input  logic [XLEN-1:0]         i_vio_pc,
    input  logic [FOLD_W-1:0]       i_vio_store_foldpc,
    input  logic [FOLD_W-1:0]       i_vio_load_foldpc,
    input  logic                    i_commit_vld,
    input  logic [RIW-1:0]          i_commit_rob_idx,
    output logic                    o_pending,
    output logic                    o_squash_vld,
    output logic                    o_squash_due_to_branch,
    output logic                    o_squash_due_to_violation,
    output logic                    o_squash_branch_taken,
    output logic [XLEN-1:0]         o_squash_arch_pc,
    output logic [FOLD_W-1:0]       o_squash_store_foldpc,
`ifdef SQUASH_ARB_PERF_EN
    output logic [31:0]             o_perf_br_squash_cnt,
    output logic [31:0]             o_perf_vio_squash_cnt,
    output logic [31:0]             o_perf_drop_cnt,
`endif
    output logic [FOLD_W-1:0]       o_squash_load_foldpc
);

    typedef enum logic [1:0] {StIdle, StPend, StFire} state_e;

    // Same flag: smaller index is older; differing flag: the index has wrapped.
    function automatic logic is_older(input logic [RIW-1:0] a, input logic [RIW-1:0] b);
        if (a[RIW-1] == b[RIW-1]) begin
            return a[RIW-2:0] < b[RIW-2:0];
        end
        return a[RIW-2:0] > b[RIW-2:0];
    endfunction

    state_e             state_q;
    logic               ent_branch_q;
    logic [RIW-1:0]     ent_idx_q;
    logic               ent_taken_q;
    logic [XLEN-1:0]    ent_pc_q;
    logic [FOLD_W-1:0]  ent_sfold_q;
    logic [FOLD_W-1:0]  ent_lfold_q;

    logic               sq_vld_q;
    logic               sq_branch_q;
    logic               sq_vio_q;
    logic               sq_taken_q;
    logic [XLEN-1:0]    sq_pc_q;
    logic [FOLD_W-1:0]  sq_sfold_q;
    logic [FOLD_W-1:0]  sq_lfold_q;

    logic               cand_vld;
    logic               cand_branch;
    logic [RIW-1:0]     cand_idx;
    logic               cand_taken;
    logic [XLEN-1:0]    cand_pc;
    logic [FOLD_W-1:0]  cand_sfold;
    logic [FOLD_W-1:0]  cand_lfold;

    logic               commit_match;
    logic               cand_replace;

    // Strict comparisons keep the lower port on ties and let branches beat the violation.
    always_comb begin
        cand_vld    = 1'b0;
        cand_branch = 1'b0;
        cand_idx    = '0;
        cand_taken  = 1'b0;
        cand_pc     = '0;
        cand_sfold  = '0;
        cand_lfold  = '0;
        for (int i = 0; i < NUM_BRU; i++) begin
            if (i_bwb_vld[i] && (!cand_vld || is_older(i_bwb_rob_idx[i*RIW +: RIW], cand_idx))) begin
                cand_vld    = 1'b1;
                cand_branch = 1'b1;
                cand_idx    = i_bwb_rob_idx[i*RIW +: RIW];
                cand_taken  = i_bwb_taken[i];
                cand_pc     = i_bwb_npc[i*XLEN +: XLEN];
                cand_sfold  = '0;
                cand_lfold  = '0;
            end
        end
        if (i_vio_vld && (!cand_vld || is_older(i_vio_rob_idx, cand_idx))) begin
            cand_vld    = 1'b1;
            cand_branch = 1'b0;
            cand_idx    = i_vio_rob_idx;
            cand_taken  = 1'b0;
            cand_pc     = i_vio_pc;
            cand_sfold  = i_vio_store_foldpc;
            cand_lfold  = i_vio_load_foldpc;
        end
    end

    assign commit_match = (state_q == StPend) && i_commit_vld && (i_commit_rob_idx == ent_idx_q);
    assign cand_replace = (state_q == StPend) && !commit_match && cand_vld &&
                          is_older(cand_idx, ent_idx_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ent_branch_q <= 1'b0;
            ent_idx_q    <= '0;
            ent_taken_q  <= 1'b0;
            ent_pc_q     <= '0;
            ent_sfold_q  <= '0;
            ent_lfold_q  <= '0;
            sq_vld_q     <= 1'b0;
            sq_branch_q  <= 1'b0;
            sq_vio_q     <= 1'b0;
            sq_taken_q   <= 1'b0;
            sq_pc_q      <= '0;
            sq_sfold_q   <= '0;
            sq_lfold_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cand_vld) begin
                        state_q      <= StPend;
                        ent_branch_q <= cand_branch;
                        ent_idx_q    <= cand_idx;
                        ent_taken_q  <= cand_taken;
                        ent_pc_q     <= cand_pc;
                        ent_sfold_q  <= cand_sfold;
                        ent_lfold_q  <= cand_lfold;
                    end
                end
                StPend: begin
                    if (commit_match) begin
                        state_q     <= StFire;
                        sq_vld_q    <= 1'b1;
                        sq_branch_q <= ent_branch_q;
                        sq_vio_q    <= !ent_branch_q;
                        sq_taken_q  <= ent_taken_q;
                        sq_pc_q     <= ent_pc_q;
                        sq_sfold_q  <= ent_sfold_q;
                        sq_lfold_q  <= ent_lfold_q;
                    end else if (cand_replace) begin
                        ent_branch_q <= cand_branch;
                        ent_idx_q    <= cand_idx;
                        ent_taken_q  <= cand_taken;
                        ent_pc_q     <= cand_pc;
                        ent_sfold_q  <= cand_sfold;
                        ent_lfold_q  <= cand_lfold;
                    end
                end
                StFire: begin
                    // Writebacks seen here are on the squashed path and are ignored.
                    state_q      <= StIdle;
                    ent_branch_q <= 1'b0;
                    ent_idx_q    <= '0;
                    ent_taken_q  <= 1'b0;
                    ent_pc_q     <= '0;
                    ent_sfold_q  <= '0;
                    ent_lfold_q  <= '0;
                    sq_vld_q     <= 1'b0;
                    sq_branch_q  <= 1'b0;
                    sq_vio_q     <= 1'b0;
                    sq_taken_q   <= 1'b0;
                    sq_pc_q      <= '0;
                    sq_sfold_q   <= '0;
                    sq_lfold_q   <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_pending                 = (state_q == StPend);
    assign o_squash_vld              = sq_vld_q;
    assign o_squash_due_to_branch    = sq_branch_q;
    assign o_squash_due_to_violation = sq_vio_q;
    assign o_squash_branch_taken     = sq_taken_q;
    assign o_squash_arch_pc          = sq_pc_q;
    assign o_squash_store_foldpc     = sq_sfold_q;
    assign o_squash_load_foldpc      = sq_lfold_q;

`ifdef SQUASH_ARB_PERF_EN
    logic [31:0] br_cnt_q;
    logic [31:0] vio_cnt_q;
    logic [31:0] drop_cnt_q;
    logic [31:0] n_valid;
    logic [31:0] n_drop;
    logic [32:0] drop_sum;

    // Every valid input seen in PEND is dropped except a winner that replaces the entry.
    always_comb begin
        n_valid = 32'(i_vio_vld);
        for (int i = 0; i < NUM_BRU; i++) begin
            n_valid = n_valid + 32'(i_bwb_vld[i]);
        end
        n_drop = '0;
        if (state_q == StPend) begin
            n_drop = n_valid - 32'(cand_replace);
        end
        drop_sum = {1'b0, drop_cnt_q} + {1'b0, n_drop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q   <= '0;
            vio_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (state_q == StFire && ent_branch_q && br_cnt_q != '1) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (state_q == StFire && !ent_branch_q && vio_cnt_q != '1) begin
                vio_cnt_q <= vio_cnt_q + 32'd1;
            end
            drop_cnt_q <= drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end

    assign o_perf_br_squash_cnt  = br_cnt_q;
    assign o_perf_vio_squash_cnt = vio_cnt_q;
    assign o_perf_drop_cnt       = drop_cnt_q;
`endif

endmodule

// File: doc/squash_arbiter.md
Name: squash_arbiter

Overview:
- Collects branch-mispredict writebacks from all BRU ports and memory-order violations from the LSU.
- Keeps only the oldest pending redirect, ordered by robIdx age.
- Fires a single-cycle squashInfo when that instruction reaches the ROB commit point. Squashes are only raised at retirement, and a squash takes priority over commit.
- Sits between the execute/LSU writeback paths and the ROB/ftq/frontend redirect network.

Parameters:
- NUM_BRU, 2, number of branch writeback ports.
- ROB_SIZE, 64, ROB entries (power of 2). RIW = $clog2(ROB_SIZE)+1 is the robIdx width: flag bit at MSB, index below it.
- XLEN, 64, pc width.
- FOLD_W, `MEMDEP_FOLDPC_WIDTH, folded-pc width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- i_bwb_vld  in  NUM_BRU  branch writeback valid with has_mispred=1
- i_bwb_rob_idx  in  NUM_BRU*RIW  robIdx per port
- i_bwb_taken  in  NUM_BRU  branch_taken per port
- i_bwb_npc  in  NUM_BRU*XLEN  correct next pc (branch_npc) per port
- i_vio_vld  in  1  load violation detected
- i_vio_rob_idx  in  RIW  robIdx of the violating load
- i_vio_pc  in  XLEN  pc of the violating load (refetch target)
- i_vio_store_foldpc  in  FOLD_W  store foldpc
- i_vio_load_foldpc  in  FOLD_W  load foldpc
- i_commit_vld  in  1  ROB head retiring this cycle
- i_commit_rob_idx  in  RIW  robIdx of the ROB head
- o_pending  out  1  a redirect is held
- o_squash_vld  out  1  squashInfo valid, one-cycle pulse
- o_squash_due_to_branch  out  1  dueToBranch
- o_squash_due_to_violation  out  1  dueToViolation
- o_squash_branch_taken  out  1  branch_taken
- o_squash_arch_pc  out  XLEN  redirect pc
- o_squash_store_foldpc  out  FOLD_W  store_foldpc
- o_squash_load_foldpc  out  FOLD_W  load_foldpc

Behaviour:
- **Age rule:** a is older than b iff (a.flag==b.flag ? a.idx<b.idx : a.idx>b.idx).
- **FSM states:** IDLE, PEND, FIRE.
- **Per-cycle candidate selection:**
  - Candidates are all valid BRU ports plus the violation.
  - Pick the oldest. On equal robIdx, the branch wins; among BRU ports, the lower port number wins.
- **Capture (registered, available the next cycle):**
  - IDLE: any valid candidate goes to PEND and stores the candidate.
  - PEND: replace the stored entry only if the candidate is strictly older. Younger or equal candidates are dropped.
- **Stored fields:**
  - type (branch or violation).
  - robIdx.
  - taken: the branch's taken bit; 0 for a violation.
  - pc: npc for a branch, i_vio_pc for a violation.
  - foldpcs: captured for a violation; 0 for a branch.
- **Fire:**
  - In PEND, i_commit_vld=1 with i_commit_rob_idx equal to the stored robIdx goes to FIRE next cycle.
  - Matching compares against the registered entry only.
  - A capture and a match on the same cycle both evaluate against the old entry.
  - FIRE: o_squash_vld=1 for exactly one cycle, fields driven from the stored entry.
  - FIRE to IDLE unconditionally, and the entry is cleared.
  - All writeback and violation inputs during FIRE are ignored (wrong path).
- **Outputs:**
  - o_pending = (state==PEND).
  - All o_squash_* fields are 0 when o_squash_vld=0.
- **Wrap:** robIdx wraps modulo 2*ROB_SIZE. The age rule must hold across the index wrap, e.g. {1,0} is younger than {0,63}.
- **Reset:** rst forces IDLE, clears the entry, and all outputs read 0 the cycle after. Reset asserted mid-PEND or mid-FIRE discards everything; no squash is emitted.
- **Latency:** writeback at cycle N, pending at N+1. Commit match at M ≥ N+1 gives o_squash_vld at M+1.

Optional Feature:
- Macro: SQUASH_ARB_PERF_EN.
- When defined:
  - Adds outputs o_perf_br_squash_cnt[31:0] and o_perf_vio_squash_cnt[31:0]. Each increments on every FIRE of its type and saturates at 0xFFFFFFFF.
  - Adds o_perf_drop_cnt[31:0], which counts candidates dropped as younger-or-equal while in PEND (one per dropped candidate per cycle).
  - Reset clears all counters to 0.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Single mispredict: bwb port0 robIdx=5, npc=0x80001000, taken=1, then commit robIdx=5 three cycles later → one-cycle o_squash_vld with due_to_branch=1, arch_pc=0x80001000, branch_taken=1; o_pending drops.
- Same-cycle race: port0 robIdx=9 and port1 robIdx=4 mispredict together, plus violation robIdx=4 → robIdx=4 branch on port1 is held; commit 4 fires a branch squash.
- Wrap: pending {0,63}, then a later candidate {1,2} → dropped; commit {0,63} fires with the original pc.
- Older replace: pending violation robIdx=20 with foldpcs 0x1A/0x2B, then branch robIdx=12 → replaced; commit 20 gives no squash; commit 12 gives due_to_branch=1 with foldpcs 0.
- Ignore during FIRE: a mispredict arrives in the FIRE cycle → no pending afterwards, state IDLE.
- Reset mid-PEND: robIdx=7 pending, rst for one cycle, then commit 7 → no squash; with SQUASH_ARB_PERF_EN, counters read 0.
